// File: rtl/qbus_master.sv
`default_nettype none
// ============================================================================
//  Module   : qbus_master
//  Purpose  : QBUS bus-cycle master for DATI, DATO(B), DATIO(B) and IAK
//             cycles, with RPLY timeout and odd-word-address trap.
//  Revision : 1.0  initial release
// ============================================================================
module qbus_master #(
    parameter int ADDR_CYC = 1,
    parameter int DATA_CYC = 1,
    parameter int TIMEOUT  = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_byte,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] rdata,
    input  logic [15:0] rmw_wdata,
    input  logic        rmw_go,
    output logic        rmw_hold,
    inout  wire  [15:0] ad,
    input  logic        rply,
    output logic        sync,
    output logic        din,
    output logic        dout,
    output logic        wtbt,
    output logic        iako
);

    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam int c_CW = (c_TW > 4) ? c_TW : 4;

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_ADDR     = 4'd1;
    localparam logic [3:0] c_RD_WAIT  = 4'd2;
    localparam logic [3:0] c_RD_END   = 4'd3;
    localparam logic [3:0] c_HOLD     = 4'd4;
    localparam logic [3:0] c_WR_SETUP = 4'd5;
    localparam logic [3:0] c_WR_WAIT  = 4'd6;
    localparam logic [3:0] c_WR_END   = 4'd7;
    localparam logic [3:0] c_IAK_DIN  = 4'd8;
    localparam logic [3:0] c_IAK_WAIT = 4'd9;
    localparam logic [3:0] c_IAK_END  = 4'd10;

    localparam logic [1:0] c_OP_WR  = 2'b01;
    localparam logic [1:0] c_OP_RMW = 2'b10;
    localparam logic [1:0] c_OP_IAK = 2'b11;

    localparam logic [c_CW-1:0] c_ADDR_LAST = c_CW'(ADDR_CYC - 1);
    localparam logic [c_CW-1:0] c_DATA_LAST = c_CW'(DATA_CYC - 1);
    localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(TIMEOUT - 1);

    logic [3:0]      r_state;
    logic [3:0]      w_state_next;
    logic [1:0]      r_op;
    logic            r_byte;
    logic [15:0]     r_addr;
    logic [15:0]     r_wdata;
    logic [15:0]     r_rdata;
    logic [c_CW-1:0] r_cnt;
    logic            r_done;
    logic            r_error;
    logic [1:0]      r_err_code;

    logic            w_accept;
    logic            w_latch_rd;
    logic            w_latch_rmw;
    logic            w_done_set;
    logic            w_err_set;
    logic [1:0]      w_code_set;
    logic            w_ad_oe;
    logic [15:0]     w_ad_out;
    logic            w_to;

    assign w_to     = (r_cnt == c_TO_LAST);
    assign ad       = w_ad_oe ? w_ad_out : 16'hzzzz;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;
    assign rdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_latch_rd   = 1'b0;
        w_latch_rmw  = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        w_code_set   = 2'b00;
        w_ad_oe      = 1'b0;
        w_ad_out     = r_wdata;
        cmd_ready    = 1'b0;
        rmw_hold     = 1'b0;
        sync         = 1'b1;
        din          = 1'b1;
        dout         = 1'b1;
        wtbt         = 1'b1;
        iako         = 1'b1;
        case (r_state)
            c_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_op != c_OP_IAK && !cmd_byte && cmd_addr[0]) begin
                        w_done_set = 1'b1;
                        w_err_set  = 1'b1;
                        w_code_set = 2'b10;
                    end else if (cmd_op == c_OP_IAK) begin
                        w_state_next = c_IAK_DIN;
                    end else begin
                        w_state_next = c_ADDR;
                    end
                end
            end
            c_ADDR: begin
                w_ad_oe  = 1'b1;
                w_ad_out = r_addr;
                wtbt     = (r_op != c_OP_WR);
                if (r_cnt == c_ADDR_LAST) begin
                    w_state_next = (r_op == c_OP_WR) ? c_WR_SETUP : c_RD_WAIT;
                end
            end
            c_RD_WAIT: begin
                sync = 1'b0;
                din  = 1'b0;
                if (!rply) begin
                    w_latch_rd   = 1'b1;
                    w_state_next = c_RD_END;
                end else if (w_to) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                    w_err_set    = 1'b1;
                    w_code_set   = 2'b01;
                end
            end
            c_RD_END: begin
                sync = 1'b0;
                if (rply) begin
                    if (r_op == c_OP_RMW) begin
                        w_state_next = c_HOLD;
                    end else begin
                        w_state_next = c_IDLE;
                        w_done_set   = 1'b1;
                    end
                end else if (w_to) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                    w_err_set    = 1'b1;
                    w_code_set   = 2'b01;
                end
            end
            c_HOLD: begin
                // Bus stays framed (SYNC low) while the client computes the write-back.
                sync     = 1'b0;
                rmw_hold = 1'b1;
                if (rmw_go) begin
                    w_latch_rmw  = 1'b1;
                    w_state_next = c_WR_SETUP;
                end
            end
            c_WR_SETUP: begin
                sync    = 1'b0;
                w_ad_oe = 1'b1;
                wtbt    = ~r_byte;
                if (r_cnt == c_DATA_LAST) begin
                    w_state_next = c_WR_WAIT;
                end
            end
            c_WR_WAIT: begin
                sync    = 1'b0;
                w_ad_oe = 1'b1;
                wtbt    = ~r_byte;
                dout    = 1'b0;
                if (!rply) begin
                    w_state_next = c_WR_END;
                end else if (w_to) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                    w_err_set    = 1'b1;
                    w_code_set   = 2'b01;
                end
            end
            c_WR_END: begin
                sync    = 1'b0;
                w_ad_oe = 1'b1;
                wtbt    = ~r_byte;
                if (rply) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                end else if (w_to) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                    w_err_set    = 1'b1;
                    w_code_set   = 2'b01;
                end
            end
            c_IAK_DIN: begin
                din          = 1'b0;
                w_state_next = c_IAK_WAIT;
            end
            c_IAK_WAIT: begin
                din  = 1'b0;
                iako = 1'b0;
                if (!rply) begin
                    w_latch_rd   = 1'b1;
                    w_state_next = c_IAK_END;
                end else if (w_to) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                    w_err_set    = 1'b1;
                    w_code_set   = 2'b01;
                end
            end
            c_IAK_END: begin
                if (rply) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                end else if (w_to) begin
                    w_state_next = c_IDLE;
                    w_done_set   = 1'b1;
                    w_err_set    = 1'b1;
                    w_code_set   = 2'b01;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // One counter serves phase lengths and the RPLY timeout; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state != c_IDLE && r_state != c_HOLD) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= 2'b00;
            r_byte     <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_rdata    <= 16'h0000;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_done     <= w_done_set;
            r_error    <= w_err_set;
            r_err_code <= w_code_set;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_byte  <= cmd_byte;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (w_latch_rd) begin
                r_rdata <= ad;
            end
            if (w_latch_rmw) begin
                r_wdata <= rmw_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qbus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qbus_master
//  Purpose  : Directed bench for qbus_master with a QBUS slave model and a
//             done-response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qbus_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_byte;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] rmw_wdata;
    logic        rmw_go;
    logic        rply;
    logic        cmd_ready;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] rdata;
    logic        rmw_hold;
    logic        sync;
    logic        din;
    logic        dout;
    logic        wtbt;
    logic        iako;
    wire  [15:0] ad;

    logic        slave_en;
    logic        slave_drive;
    logic [15:0] slave_rdata;
    logic [15:0] wr_cap;
    logic        prev_low;

    int total;
    int bad;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [15:0] rd;
    } exp_t;
    exp_t sbq[$];

    // Bus-monitor statistics, written only by the monitor process.
    logic [15:0] addr_ref;
    logic [15:0] setup_ref;
    int n_addr, n_setup, n_setup_match, n_setup_wtbt0;
    int n_din_low, n_sync_low, n_act, n_hold, n_hold_sync_hi;
    logic seen_din_low, seen_dout_low;

    assign ad = slave_drive ? slave_rdata : 16'hzzzz;

    qbus_master #(.ADDR_CYC(1), .DATA_CYC(3), .TIMEOUT(63)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_byte(cmd_byte), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .done(done), .error(error), .err_code(err_code), .rdata(rdata),
        .rmw_wdata(rmw_wdata), .rmw_go(rmw_go), .rmw_hold(rmw_hold),
        .ad(ad), .rply(rply), .sync(sync), .din(din), .dout(dout),
        .wtbt(wtbt), .iako(iako)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave: asserts RPLY after a strobe has been low for a full cycle, releases
    // it after the strobe has been high for a full cycle.
    initial begin
        rply        = 1'b1;
        slave_drive = 1'b0;
        wr_cap      = 16'h0000;
        prev_low    = 1'b0;
        forever begin
            logic low;
            @(negedge clk);
            low = !din || !dout;
            if (!slave_en) begin
                rply        = 1'b1;
                slave_drive = 1'b0;
            end else if (low && prev_low && rply) begin
                rply = 1'b0;
                if (!din)  slave_drive = 1'b1;
                if (!dout) wr_cap = ad;
            end else if (!low && !prev_low && !rply) begin
                rply        = 1'b1;
                slave_drive = 1'b0;
            end
            prev_low = low;
        end
    end

    initial begin
        n_addr = 0; n_setup = 0; n_setup_match = 0; n_setup_wtbt0 = 0;
        n_din_low = 0; n_sync_low = 0; n_act = 0; n_hold = 0; n_hold_sync_hi = 0;
        seen_din_low = 1'b0; seen_dout_low = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (sync === 1'b1) begin
                seen_din_low  = 1'b0;
                seen_dout_low = 1'b0;
                if (!slave_drive && ad === addr_ref) n_addr++;
            end
            if (sync === 1'b0 && dout === 1'b1 && din === 1'b1 && rmw_hold === 1'b0 &&
                !seen_din_low && !seen_dout_low) begin
                n_setup++;
                if (ad === setup_ref) n_setup_match++;
                if (wtbt === 1'b0)    n_setup_wtbt0++;
            end
            if (din === 1'b0)  begin n_din_low++; seen_din_low = 1'b1; end
            if (dout === 1'b0) seen_dout_low = 1'b1;
            if (sync === 1'b0) n_sync_low++;
            if (sync === 1'b0 || din === 1'b0 || dout === 1'b0) n_act++;
            if (rmw_hold === 1'b1) begin
                n_hold++;
                if (sync === 1'b1) n_hold_sync_hi++;
            end
        end
    end

    // Scoreboard: every done pulse must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("done_error", {31'd0, error}, {31'd0, e.err});
                    check("done_err_code", {30'd0, err_code}, {30'd0, e.code});
                    check("done_rdata", {16'd0, rdata}, {16'd0, e.rd});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_done(input logic err, input logic [1:0] code, input logic [15:0] rd);
        exp_t e;
        e.err = err; e.code = code; e.rd = rd;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic b, input logic [15:0] a, input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("issue_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_byte = b; cmd_addr = a; cmd_wdata = w;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int s_addr, s_setup, s_match, s_wtbt0, s_din, s_sync, s_act, s_hold, s_hsync;
        int n;
        total = 0; bad = 0;
        cmd_valid = 1'b0; cmd_byte = 1'b0; cmd_op = 2'b00;
        cmd_addr = 16'h0000; cmd_wdata = 16'h0000;
        rmw_wdata = 16'h0000; rmw_go = 1'b0;
        slave_en = 1'b1; slave_rdata = 16'h0000;
        addr_ref = 16'hFFFF; setup_ref = 16'hFFFF;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {27'd0, sync, din, dout, wtbt, iako}, 32'h1F);
        check("rst_done_err", {29'd0, done, error, rmw_hold}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Word read of 0o177560 returning 0o000200
        addr_ref = 16'hFF70; slave_rdata = 16'h0080;
        s_addr = n_addr;
        expect_done(1'b0, 2'b00, 16'h0080);
        issue(2'b00, 1'b0, 16'hFF70, 16'h0000);
        @(negedge clk);
        check("rd_busy_ready", {31'd0, cmd_ready}, 32'd0);
        wait_done(50, "rd");
        check("rd_sync_at_done", {31'd0, sync}, 32'd1);
        #2;
        check("rd_addr_cycles", n_addr - s_addr, 32'd1);

        // Byte write 0x00A5 to 0o001001, three data setup cycles
        setup_ref = 16'h00A5; addr_ref = 16'h0201;
        s_setup = n_setup; s_match = n_setup_match; s_wtbt0 = n_setup_wtbt0;
        expect_done(1'b0, 2'b00, 16'h0080);
        issue(2'b01, 1'b1, 16'h0201, 16'h00A5);
        wait_done(50, "wrb");
        #2;
        check("wrb_setup_cycles", n_setup - s_setup, 32'd3);
        check("wrb_setup_ad", n_setup_match - s_match, 32'd3);
        check("wrb_setup_wtbt0", n_setup_wtbt0 - s_wtbt0, 32'd3);
        check("wrb_slave_data", {16'd0, wr_cap}, 32'h00A5);

        // Word read at odd address: trapped without bus activity
        s_act = n_act; s_addr = n_addr;
        expect_done(1'b1, 2'b10, 16'h0080);
        issue(2'b00, 1'b0, 16'h0201, 16'h0000);
        wait_done(5, "odd");
        #2;
        check("odd_bus_activity", n_act - s_act, 32'd0);
        check("odd_addr_cycles", n_addr - s_addr, 32'd0);

        // Read with no reply: 63 RD_WAIT cycles then timeout
        slave_en = 1'b0;
        s_din = n_din_low;
        expect_done(1'b1, 2'b01, 16'h0080);
        issue(2'b00, 1'b0, 16'h0100, 16'h0000);
        wait_done(100, "to");
        #2;
        check("to_din_cycles", n_din_low - s_din, 32'd63);
        check("to_strobes_idle", {29'd0, sync, din, dout}, 32'h7);
        check("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        slave_en = 1'b1;

        // DATIO at 0o000100: read 0x1234, long hold, write back 0x1235
        slave_rdata = 16'h1234;
        expect_done(1'b0, 2'b00, 16'h1234);
        issue(2'b10, 1'b0, 16'h0040, 16'h0000);
        n = 0;
        @(negedge clk);
        while (rmw_hold !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rmw_hold_seen", {31'd0, rmw_hold}, 32'd1);
        check("rmw_read_data", {16'd0, rdata}, 32'h1234);
        #2;
        s_hold = n_hold; s_hsync = n_hold_sync_hi;
        repeat (100) @(negedge clk);
        rmw_wdata = 16'h1235;
        rmw_go = 1'b1;
        @(posedge clk);
        #1;
        rmw_go = 1'b0;
        rmw_wdata = 16'h0000;
        wait_done(50, "rmw");
        #2;
        check("rmw_hold_long", {31'd0, (n_hold - s_hold) >= 100}, 32'd1);
        check("rmw_hold_sync_low", n_hold_sync_hi - s_hsync, 32'd0);
        check("rmw_write_data", {16'd0, wr_cap}, 32'h1235);

        // Interrupt acknowledge returning vector 0o000060
        slave_rdata = 16'h0030;
        s_sync = n_sync_low;
        expect_done(1'b0, 2'b00, 16'h0030);
        issue(2'b11, 1'b0, 16'h0000, 16'h0000);
        wait_done(50, "iak");
        #2;
        check("iak_sync_low", n_sync_low - s_sync, 32'd0);

        // Reset during RD_WAIT of a read that never gets a reply
        slave_en = 1'b0;
        issue(2'b00, 1'b0, 16'h0100, 16'h0000);
        n = 0;
        @(negedge clk);
        while (din !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_rd_wait", {31'd0, din}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_strobes", {27'd0, sync, din, dout, wtbt, iako}, 32'h1F);
        check("abort_done_hold", {29'd0, done, error, rmw_hold}, 32'd0);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check("pending_expectations", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
